// File: rtl/handshake_pkg.sv
// -----------------------------------------------------------------------------
// handshake_pkg
//
// Shared helpers for the handshake dataflow library. It holds only the
// ceiling-log2 width function. Buffers use it to size their pointers and
// token counters.
// -----------------------------------------------------------------------------
package handshake_pkg;

   // Number of bits needed to index 'value' distinct items. Returns 0 for
   // value <= 1. Callers that need a minimum width of 1 apply that
   // themselves.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/oehb_fifo_dataless.sv
// -----------------------------------------------------------------------------
// oehb_fifo_dataless
//
// Control half of the opaque elastic FIFO. It holds the circular-buffer
// pointers, the token count and the valid/ready handshake. It stores no
// payload, so a dataless channel can use it unchanged. A data-carrying
// wrapper keeps its own storage and writes it with wr_en/wr_ptr.
//
// Parameters:
//   NUM_SLOTS   capacity in tokens (>= 1, any value, not only powers of two)
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous reset, active low
//   ins_valid   producer offers a token
//   ins_ready   a token is accepted this cycle
//                 (not full, or the head leaves this cycle)
//   outs_valid  head token present; driven purely from the count register
//   outs_ready  consumer accepts the head token
//   wr_en       write strobe for the payload storage
//   wr_ptr      slot written when wr_en is high
//   rd_ptr      slot holding the head token
//   count       stored token count (only with OEHB_FIFO_OCC_EN)
//
// Optional feature macro: OEHB_FIFO_OCC_EN adds the 'count' output.
// -----------------------------------------------------------------------------
module oehb_fifo_dataless
   import handshake_pkg::*;
#(
   parameter  int NUM_SLOTS = 2,
   localparam int PTR_W     = (NUM_SLOTS > 1) ? clog2(NUM_SLOTS) : 1,
   localparam int CNT_W     = clog2(NUM_SLOTS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ins_valid,
   output logic             ins_ready,
   output logic             outs_valid,
   input  logic             outs_ready,
   output logic             wr_en,
   output logic [PTR_W-1:0] wr_ptr,
   output logic [PTR_W-1:0] rd_ptr
`ifdef OEHB_FIFO_OCC_EN
   ,
   output logic [CNT_W-1:0] count
`endif
);

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLOTS - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);

   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] rd_ptr_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             rd_en;

   // The wrap is explicit so that capacities that are not powers of two
   // cycle through exactly NUM_SLOTS slots.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
   endfunction

   // outs_valid comes only from a register, which cuts the forward path.
   assign outs_valid = (count_q != '0);

   // ready depends combinationally only on outs_ready. When the FIFO is
   // full and the head leaves this cycle, the incoming token may take the
   // slot being read.
   assign ins_ready  = (count_q != FULL_CNT) | outs_ready;

   assign wr_en      = ins_valid & ins_ready;
   assign rd_en      = outs_valid & outs_ready;

   assign wr_ptr     = wr_ptr_q;
   assign rd_ptr     = rd_ptr_q;

`ifdef OEHB_FIFO_OCC_EN
   assign count      = count_q;
`endif

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         wr_ptr_d = next_ptr(wr_ptr_q);
      end
      if (rd_en) begin
         rd_ptr_d = next_ptr(rd_ptr_q);
      end
      // A simultaneous read and write leaves the count unchanged.
      if (wr_en && !rd_en) begin
         count_d = count_q + CNT_W'(1);
      end else if (rd_en && !wr_en) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/oehb_fifo.sv
// -----------------------------------------------------------------------------
// oehb_fifo
//
// Opaque elastic FIFO. It is a circular buffer of NUM_SLOTS tokens whose
// forward path (outs, outs_valid) is fully registered: no combinational
// path runs from ins/ins_valid to the outputs. It sustains one token per
// cycle when both sides are always ready, with a one-cycle minimum latency.
//
// Parameters:
//   DATA_WIDTH  payload width (>= 1)
//   NUM_SLOTS   capacity in tokens (>= 1, need not be a power of two)
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous reset, active low; clears every slot
//   ins         input token data
//   ins_valid   producer offers a token
//   ins_ready   FIFO accepts a token this cycle
//   outs        head token data (registered slot contents)
//   outs_valid  head token present
//   outs_ready  consumer accepts the head token
//   occupancy   stored token count (only with OEHB_FIFO_OCC_EN)
//
// Optional feature macro: OEHB_FIFO_OCC_EN adds the 'occupancy' port.
// -----------------------------------------------------------------------------
module oehb_fifo
   import handshake_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int NUM_SLOTS  = 2
`ifdef OEHB_FIFO_OCC_EN
   ,
   localparam int CNT_W      = clog2(NUM_SLOTS + 1)
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] ins,
   input  logic                  ins_valid,
   output logic                  ins_ready,
   output logic [DATA_WIDTH-1:0] outs,
   output logic                  outs_valid,
   input  logic                  outs_ready
`ifdef OEHB_FIFO_OCC_EN
   ,
   output logic [CNT_W-1:0]      occupancy
`endif
);

   localparam int PTR_W = (NUM_SLOTS > 1) ? clog2(NUM_SLOTS) : 1;

   logic             wr_en;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   logic [DATA_WIDTH-1:0] slot_rd [NUM_SLOTS];

   oehb_fifo_dataless #(
      .NUM_SLOTS (NUM_SLOTS)
   ) u_ctrl (
      .clk        (clk),
      .rst        (rst),
      .ins_valid  (ins_valid),
      .ins_ready  (ins_ready),
      .outs_valid (outs_valid),
      .outs_ready (outs_ready),
      .wr_en      (wr_en),
      .wr_ptr     (wr_ptr),
      .rd_ptr     (rd_ptr)
`ifdef OEHB_FIFO_OCC_EN
      ,
      .count      (occupancy)
`endif
   );

   // Each slot is its own register so that reset clears all stored data.
   // The output then reads 0 while empty after reset.
   generate
      for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         logic [DATA_WIDTH-1:0] data_q;
         logic                  hit;

         assign hit = wr_en && (wr_ptr == PTR_W'(gi));

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               data_q <= '0;
            end else if (hit) begin
               data_q <= ins;
            end
         end

         assign slot_rd[gi] = data_q;
      end
   endgenerate

   // The head select uses only registered pointers and slots, so outs has
   // no combinational path from the input side.
   always_comb begin
      outs = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (rd_ptr == PTR_W'(i)) begin
            outs = slot_rd[i];
         end
      end
   end

endmodule

// File: tb/tb_oehb_fifo.sv
module tb_oehb_fifo;

   localparam int W = 16;

   logic clk;
   int   total;
   int   bad;
   int   cyc;

   // instance A: NUM_SLOTS=2 (fill/stall, full read+write, reset)
   logic         a_rst, a_iv, a_ir, a_ov, a_or;
   logic [W-1:0] a_ins, a_outs;
   // instance B: NUM_SLOTS=3 (streaming across a non-power-of-two wrap)
   logic         b_rst, b_iv, b_ir, b_ov, b_or;
   logic [W-1:0] b_ins, b_outs;
   // instance C: NUM_SLOTS=1 (random handshakes)
   logic         c_rst, c_iv, c_ir, c_ov, c_or;
   logic [W-1:0] c_ins, c_outs;
`ifdef OEHB_FIFO_OCC_EN
   logic [1:0]   a_occ, b_occ;
   logic [0:0]   c_occ;
`endif

   logic [W-1:0] qa[$];
   logic [W-1:0] qb[$];
   logic [W-1:0] qc[$];

   int b_first_push, b_first_pop, b_last_pop, b_pops;
   int c_pops;

   oehb_fifo #(.DATA_WIDTH(W), .NUM_SLOTS(2)) u_a (
      .clk(clk), .rst(a_rst), .ins(a_ins), .ins_valid(a_iv), .ins_ready(a_ir),
      .outs(a_outs), .outs_valid(a_ov), .outs_ready(a_or)
`ifdef OEHB_FIFO_OCC_EN
      , .occupancy(a_occ)
`endif
   );

   oehb_fifo #(.DATA_WIDTH(W), .NUM_SLOTS(3)) u_b (
      .clk(clk), .rst(b_rst), .ins(b_ins), .ins_valid(b_iv), .ins_ready(b_ir),
      .outs(b_outs), .outs_valid(b_ov), .outs_ready(b_or)
`ifdef OEHB_FIFO_OCC_EN
      , .occupancy(b_occ)
`endif
   );

   oehb_fifo #(.DATA_WIDTH(W), .NUM_SLOTS(1)) u_c (
      .clk(clk), .rst(c_rst), .ins(c_ins), .ins_valid(c_iv), .ins_ready(c_ir),
      .outs(c_outs), .outs_valid(c_ov), .outs_ready(c_or)
`ifdef OEHB_FIFO_OCC_EN
      , .occupancy(c_occ)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- monitors: sample at negedge, model is the queue -------
   always @(negedge clk) begin
      if (!a_rst) begin
         qa.delete();
      end else begin
         chk("a_valid", {31'd0, a_ov}, {31'd0, qa.size() != 0});
         chk("a_ready", {31'd0, a_ir}, {31'd0, (qa.size() != 2) | a_or});
`ifdef OEHB_FIFO_OCC_EN
         chk("a_occ", {30'd0, a_occ}, qa.size());
`endif
         if (a_ov && a_or && qa.size() != 0) begin
            chk("a_data", {16'd0, a_outs}, {16'd0, qa.pop_front()});
         end
         if (a_iv && a_ir) qa.push_back(a_ins);
      end
   end

   always @(negedge clk) begin
      if (b_rst) begin
         chk("b_valid", {31'd0, b_ov}, {31'd0, qb.size() != 0});
         chk("b_ready", {31'd0, b_ir}, {31'd0, (qb.size() != 3) | b_or});
`ifdef OEHB_FIFO_OCC_EN
         chk("b_occ", {30'd0, b_occ}, qb.size());
`endif
         if (b_ov && b_or && qb.size() != 0) begin
            chk("b_data", {16'd0, b_outs}, {16'd0, qb.pop_front()});
            if (b_first_pop < 0) b_first_pop = cyc;
            b_last_pop = cyc;
            b_pops     = b_pops + 1;
         end
         if (b_iv && b_ir) begin
            if (b_first_push < 0) b_first_push = cyc;
            qb.push_back(b_ins);
         end
      end
   end

   always @(negedge clk) begin
      if (c_rst) begin
         // valid must not rise before the write edge has passed
         chk("c_valid", {31'd0, c_ov}, {31'd0, qc.size() != 0});
         chk("c_ready", {31'd0, c_ir}, {31'd0, (qc.size() != 1) | c_or});
`ifdef OEHB_FIFO_OCC_EN
         chk("c_occ", {31'd0, c_occ}, qc.size());
`endif
         if (c_ov && c_or && qc.size() != 0) begin
            chk("c_data", {16'd0, c_outs}, {16'd0, qc.pop_front()});
            c_pops = c_pops + 1;
         end
         if (c_iv && c_ir) qc.push_back(c_ins);
      end
   end

   // ---------------- stimulus helpers --------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_put(input logic [W-1:0] d);
      logic acc;
      acc   = 1'b0;
      a_ins = d;
      a_iv  = 1'b1;
      for (int t = 0; t < 50 && !acc; t++) begin
         @(negedge clk);
         if (a_ir) acc = 1'b1;
         else tick();
      end
      chk("a_put_accept", {31'd0, acc}, 32'd1);
      tick();
      a_iv = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0; bad = 0; cyc = 0;
      b_first_push = -1; b_first_pop = -1; b_last_pop = -1; b_pops = 0; c_pops = 0;
      a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
      a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0;
      a_or = 1'b0; b_or = 1'b0; c_or = 1'b0;
      a_ins = '0; b_ins = '0; c_ins = '0;
      #1;
      a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
      repeat (2) tick();
      chk("reset_a_valid", {31'd0, a_ov}, 32'd0);
      chk("reset_a_outs", {16'd0, a_outs}, 32'd0);
      chk("reset_a_ready", {31'd0, a_ir}, 32'd1);
      @(negedge clk);
      a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
      tick();

      // ---- fill/stall: 0xA, 0xB with the consumer stalled
      a_put(16'h000A);
      a_put(16'h000B);
      chk("fill_ready_low", {31'd0, a_ir}, 32'd0);
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         chk("stall_outs", {16'd0, a_outs}, 32'h000A);
         chk("stall_valid", {31'd0, a_ov}, 32'd1);
      end
      tick();

      // ---- full with simultaneous read and write of 0xC
      a_or = 1'b1;
      a_put(16'h000C);
      a_or = 1'b0;
      #1;
      chk("full_rw_still_full", {31'd0, a_ir}, 32'd0);
      chk("full_rw_head", {16'd0, a_outs}, 32'h000B);
      a_or = 1'b1;
      repeat (3) tick();
      a_or = 1'b0;
      chk("full_rw_drained", {31'd0, a_ov}, 32'd0);
      chk("full_rw_queue", qa.size(), 32'd0);

`ifdef OEHB_FIFO_OCC_EN
      // ---- occupancy 0 -> 1 -> 2 -> 1 -> 0
      chk("occ0", {30'd0, a_occ}, 32'd0);
      a_put(16'h0101);
      chk("occ1", {30'd0, a_occ}, 32'd1);
      a_put(16'h0202);
      chk("occ2", {30'd0, a_occ}, 32'd2);
      a_or = 1'b1;
      tick();
      chk("occ1_rd", {30'd0, a_occ}, 32'd1);
      tick();
      chk("occ0_rd", {30'd0, a_occ}, 32'd0);
      a_or = 1'b0;
`endif

      // ---- reset mid-stream with two tokens stored
      a_put(16'h0011);
      a_put(16'h0022);
      #2;
      a_rst = 1'b0;
      #1;
      chk("midrst_valid", {31'd0, a_ov}, 32'd0);
      chk("midrst_outs", {16'd0, a_outs}, 32'd0);
      chk("midrst_ready", {31'd0, a_ir}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      a_rst = 1'b1;
      tick();
      a_put(16'h0033);
      chk("postrst_head", {16'd0, a_outs}, 32'h0033);
      a_or = 1'b1;
      repeat (3) tick();
      a_or = 1'b0;
      chk("postrst_queue", qa.size(), 32'd0);

      // ---- streaming on NUM_SLOTS=3
      b_or = 1'b1;
      for (int i = 0; i < 100; i++) begin
         b_ins = W'(16'h1000 + i);
         b_iv  = 1'b1;
         tick();
      end
      b_iv = 1'b0;
      repeat (5) tick();
      chk("stream_latency", b_first_pop - b_first_push, 32'd1);
      chk("stream_span", b_last_pop - b_first_pop, 32'd99);
      chk("stream_count", b_pops, 32'd100);

      // ---- random valid/ready on NUM_SLOTS=1
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               int   idle;
               logic acc;
               idle = $urandom_range(0, 2);
               if (idle > 0) begin
                  c_iv = 1'b0;
                  repeat (idle) tick();
               end
               c_ins = W'($urandom);
               c_iv  = 1'b1;
               acc   = 1'b0;
               for (int t = 0; t < 200 && !acc; t++) begin
                  @(negedge clk);
                  if (c_ir) acc = 1'b1;
                  else tick();
               end
               if (!acc) chk("rand_put_accept", {31'd0, acc}, 32'd1);
               tick();
            end
            c_iv = 1'b0;
         end
         begin
            for (int t = 0; t < 20000 && c_pops < 1000; t++) begin
               c_or = 1'($urandom_range(0, 1));
               tick();
            end
            c_or = 1'b0;
         end
      join
      chk("rand_count", c_pops, 32'd1000);
      chk("rand_queue", qc.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/oehb_fifo.md
# oehb_fifo

Opaque elastic FIFO for the handshake dataflow library, and the timing complement of the transparent half buffer: it registers the forward path (`outs`, `outs_valid`) rather than the backward `ready` path. It holds up to `NUM_SLOTS` tokens in a circular buffer. It gives full throughput under steady streaming. No combinational path exists from `ins`/`ins_valid` to `outs`/`outs_valid`. The buffering pass inserts it wherever a valid/data critical path must be cut.

## Interface
- `DATA_WIDTH`, 32: token payload width; must be ≥1.
- `NUM_SLOTS`, 2: capacity in tokens; must be ≥1; need not be a power of two.
- `clk`  input  1  clock, rising edge.
- `rst`  input  1  reset, asynchronous, active-low (asserted at 0).
- `ins`  input  DATA_WIDTH  input token data.
- `ins_valid`  input  1  producer offers a token.
- `ins_ready`  output  1  FIFO accepts a token this cycle.
- `outs`  output  DATA_WIDTH  head token data.
- `outs_valid`  output  1  head token present.
- `outs_ready`  input  1  consumer accepts the head token.
- `occupancy`  output  CNT_W  stored token count; present only with `OEHB_FIFO_OCC_EN`. CNT_W = clog2(NUM_SLOTS+1).

## Operation
- Handshake:
  - A transfer occurs on a side when valid and ready are both 1 at a rising clock edge.
  - The producer holds `ins`/`ins_valid` until accepted.
  - The FIFO holds `outs`/`outs_valid` stable until accepted.
- State registers: `mem[NUM_SLOTS]`, `rd_ptr`, `wr_ptr` (each 0..NUM_SLOTS-1), and `count` (0..NUM_SLOTS).
- `outs_valid = (count != 0)`.
- `outs = mem[rd_ptr]`.
- `ins_ready = (count != NUM_SLOTS) | outs_ready`.
- Write event (`ins_valid & ins_ready`): `mem[wr_ptr] <= ins`, and `wr_ptr` advances.
- Read event (`outs_valid & outs_ready`): `rd_ptr` advances.
- Pointer advance: value+1, or 0 when value == NUM_SLOTS-1 (explicit wrap, no modulo-2^n reliance).
- Count update: +1 on write only; −1 on read only; unchanged on both or neither.
- Full with `outs_ready=1`: a write and a read occur in the same cycle. The write overwrites the slot being read, which is legal because the read completes at that edge. Count stays NUM_SLOTS.
- Empty with `ins_valid=1`: the token is written. `outs_valid` rises the next cycle. No bypass.
- Ordering: strict FIFO order; no token is dropped or duplicated.
- Reset (async, while `rst`=0):
  - `count`=0, `rd_ptr`=`wr_ptr`=0, all `mem` entries 0.
  - Hence `outs`=0, `outs_valid`=0, and `ins_ready`=1.
  - Reset mid-operation discards all stored tokens immediately.

## Timing
- Latency: one cycle minimum from an `ins` transfer to `outs_valid`.
- Throughput: one token per cycle sustained when both sides are always ready.
- `outs` and `outs_valid` depend only on registers.
- `ins_ready` has a single combinational dependency, on `outs_ready`. A tehb must not be placed immediately downstream if a registered `ready` is required at both ends.
- Reset deassertion is not required to be glitch-free at this level. A reset synchronizer upstream guarantees release synchronous to `clk`.

## Configuration
- `OEHB_FIFO_OCC_EN` defined: the `occupancy` port exists and equals `count`. Reset value is 0.
- Macro absent: the port is omitted entirely. Behaviour on all other ports is identical.

## Structure
- Shared `handshake_pkg` holds the clog2-based width function for CNT_W.
- No other shared typedefs. Pointer and count widths are local constants.
- One sub-module: `oehb_fifo_dataless`, containing the pointer, count, valid and ready logic.
  - Ports: `clk`, `rst`, `ins_valid`, `ins_ready`, `outs_valid`, `outs_ready`, `wr_en`, `wr_ptr`, `rd_ptr`.
  - The top level owns `mem`, so dataless channels reuse the control unchanged.

## Test plan
- Reset: `rst`=0 mid-stream with count=2 → `outs_valid`=0, `outs`=0 and `ins_ready`=1 immediately; after release, the next token out is the first one written after reset.
- Fill/stall, NUM_SLOTS=2: write 0xA, 0xB with `outs_ready`=0 → `ins_ready`=0 after the second write; `outs`=0xA held stable for 5 stall cycles.
- Full with simultaneous read/write, NUM_SLOTS=2: write 0xC while full and `outs_ready`=1 → output sequence 0xA, 0xB, 0xC; count stays 2.
- Streaming, NUM_SLOTS=3 (non-power-of-two wrap): 100 sequential values with both sides always ready → one token per cycle after a 1-cycle latency; exact order preserved across pointer wrap.
- Random valid/ready, NUM_SLOTS=1: 1000 tokens → scoreboard matches, no loss or duplication; `outs_valid` never rises in the same cycle as the first write to an empty FIFO.
- With `OEHB_FIFO_OCC_EN`: `occupancy` tracks 0→1→2→1→0 over a write, write, read, read sequence.
